// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU front end.
//   - Fetch exception cause codes
//   - Reset PC and the NOP word used for exception and reset entries
//   - Fetch FSM state type and the fetch output-entry record
//   - pc_misaligned(): alignment check on a fetch address
package cpu_pkg;

  localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000;

  typedef enum logic {
    RUN        = 1'b0,
    FAULT_HOLD = 1'b1
  } fetch_state_e;

  // One fetched instruction plus its exception side information.
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } fetch_entry_t;

  // Instructions are 4-byte aligned; any low address bit set is a fault.
  function automatic logic pc_misaligned(input logic [63:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch initiator.
//   Owns the PC, drives a combinational instruction memory, and presents each
//   fetched instruction to decode through a single-entry valid/ready register.
//   Fetch exceptions (misaligned PC, imem access fault) travel with the entry.
//   After an exception the unit parks in FAULT_HOLD until a trap or redirect.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   pc_addr             fetch address to imem (the PC register)
//   imem_instr/exc_*    imem response for pc_addr, same cycle
//   redirect_en/pc      branch/jump redirect from execute
//   trap_en/pc          trap/mret redirect, wins over redirect_en
//   out_valid/ready     handshake with decode
//   out_instr/pc/exc_*  fetched entry and its exception information
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  input  logic        trap_en,
  input  logic [63:0] trap_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  fetch_entry_t entry_q, entry_d;

  logic xfer_s;
  logic can_load_s;

  // The output register may refill in the same cycle its entry leaves.
  assign xfer_s     = valid_q && out_ready;
  assign can_load_s = !valid_q || xfer_s;

  // Next-state logic: redirects first, then drain and capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    entry_d = entry_q;

    if (trap_en) begin
      pc_d    = trap_pc;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (redirect_en) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = RUN;
    end else begin
      if (xfer_s) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end

      case (state_q)
        RUN: begin
          if (can_load_s) begin
            valid_d    = 1'b1;
            entry_d.pc = pc_q;
            if (pc_misaligned(pc_q)) begin
              // imem response is meaningless for a misaligned address.
              entry_d.instr    = NOP_INSTR;
              entry_d.exc_en   = 1'b1;
              entry_d.exc_code = EXC_INSTR_MISALIGNED;
              entry_d.exc_val  = pc_q;
              state_d          = FAULT_HOLD;
            end else if (imem_exc_en) begin
              entry_d.instr    = NOP_INSTR;
              entry_d.exc_en   = 1'b1;
              entry_d.exc_code = imem_exc_code;
              entry_d.exc_val  = imem_exc_val;
              state_d          = FAULT_HOLD;
            end else begin
              entry_d.instr    = imem_instr;
              entry_d.exc_en   = 1'b0;
              entry_d.exc_code = 4'd0;
              entry_d.exc_val  = 64'd0;
              pc_d             = pc_q + 64'd4;
              state_d          = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        FAULT_HOLD: begin
          // PC stays on the faulting address so it is captured only once.
          state_d = FAULT_HOLD;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State, PC and output-entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      entry_q <= '{instr: NOP_INSTR, pc: 64'd0, exc_en: 1'b0,
                   exc_code: 4'd0, exc_val: 64'd0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign pc_addr      = pc_q;
  assign out_valid    = valid_q;
  assign out_instr    = entry_q.instr;
  assign out_pc       = entry_q.pc;
  assign out_exc_en   = entry_q.exc_en;
  assign out_exc_code = entry_q.exc_code;
  assign out_exc_val  = entry_q.exc_val;

endmodule
